bypass_scoreboard: RTL and testbench

Parametrised operand-bypass and interlock controller for the in-order pipeline. Replaces fixed 3-stage forwarding with N read ports and M producer stages, and adds a register scoreboard for long-latency producers (divider, CSR reads) that complete outside the pipeline. Each cycle it selects the bypass source for every ID-stage operand and raises `stall` when no ready value exists. It sits beside the ID stage and drives the operand muxes and the ID/EX pipeline enable.

---
 rtl/bypass_scoreboard_pkg.sv | 18 +
 rtl/bypass_scoreboard_if.sv | 45 ++++
 rtl/bypass_match.sv | 54 +++++
 rtl/bypass_scoreboard.sv | 117 +++++++++++
 tb/tb_bypass_scoreboard.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/bypass_scoreboard_pkg.sv
// bypass_pkg: shared constants and select-code helpers for the operand bypass
// and interlock controller.
package bypass_pkg;

    localparam int REG_AW = 5;
    localparam int SEL_RF = 0;

    // Select code for forwarding stage k (stage 0 is the youngest, EX)
    function automatic int sel_stage(input int k);
        return k + 1;
    endfunction

    // Select code for the long-op completion bus, just past the last stage
    function automatic int SEL_LO(input int num_stg);
        return num_stg + 1;
    endfunction

endpackage

// File: rtl/bypass_scoreboard_if.sv
// Bundle of ID-stage operand, producer-stage and long-op signals seen by the
// bypass/interlock controller. Optional perf counters exist only when
// BYPASS_PERF_EN is defined.
interface bypass_scoreboard_if #(
    parameter int NUM_SRC = 2,
    parameter int NUM_STG = 3,
    parameter int SEL_W   = $clog2(NUM_STG + 2)
) ();
    logic [NUM_SRC-1:0]       id_src_en;
    logic [NUM_SRC*5-1:0]     id_src_addr;
    logic [NUM_STG-1:0]       stg_gr_we;
    logic [NUM_STG*5-1:0]     stg_dest;
    logic [NUM_STG-1:0]       stg_data_ok;
    logic                     lo_issue;
    logic [4:0]               lo_dest;
    logic                     lo_done;
    logic [4:0]               lo_done_dest;
    logic [NUM_SRC*SEL_W-1:0] src_sel;
    logic                     stall;
    logic [31:0]              busy_vec;
`ifdef BYPASS_PERF_EN
    logic [31:0]              perf_ld_stall;
    logic [31:0]              perf_lo_stall;
`endif

    // Pipeline side: drives operands and producer state, consumes selects
    modport master (
        output id_src_en, id_src_addr, stg_gr_we, stg_dest, stg_data_ok,
        output lo_issue, lo_dest, lo_done, lo_done_dest,
`ifdef BYPASS_PERF_EN
        input  perf_ld_stall, perf_lo_stall,
`endif
        input  src_sel, stall, busy_vec
    );

    // Controller side
    modport slave (
        input  id_src_en, id_src_addr, stg_gr_we, stg_dest, stg_data_ok,
        input  lo_issue, lo_dest, lo_done, lo_done_dest,
`ifdef BYPASS_PERF_EN
        output perf_ld_stall, perf_lo_stall,
`endif
        output src_sel, stall, busy_vec
    );
endinterface

// File: rtl/bypass_match.sv
// bypass_match: combinational priority matcher for one ID-stage operand.
// Youngest matching stage wins, then the long-op completion bus, then the
// register file. A stage match with data not yet available is a load-use
// stall; a busy register with no bypass source is a scoreboard stall.
module bypass_match
    import bypass_pkg::*;
#(
    parameter int NUM_STG = 3,
    parameter int SEL_W   = $clog2(NUM_STG + 2)
) (
    input  logic                    src_en,
    input  logic [REG_AW-1:0]       src_addr,
    input  logic                    src_busy,
    input  logic [NUM_STG-1:0]      stg_gr_we,
    input  logic [NUM_STG*REG_AW-1:0] stg_dest,
    input  logic [NUM_STG-1:0]      stg_data_ok,
    input  logic                    lo_done,
    input  logic [REG_AW-1:0]       lo_done_dest,
    output logic [SEL_W-1:0]        sel,
    output logic                    ld_stall,
    output logic                    lo_stall
);

    logic src_valid;
    logic stg_hit;

    assign src_valid = src_en && (src_addr != '0);

    // Priority search over producers; r0 and disabled operands stay on the RF
    always_comb begin
        sel      = SEL_W'(SEL_RF);
        ld_stall = 1'b0;
        lo_stall = 1'b0;
        stg_hit  = 1'b0;
        if (src_valid) begin
            for (int k = 0; k < NUM_STG; k++) begin
                if (!stg_hit && stg_gr_we[k] &&
                    (stg_dest[k*REG_AW +: REG_AW] == src_addr)) begin
                    stg_hit  = 1'b1;
                    sel      = SEL_W'(sel_stage(k));
                    ld_stall = !stg_data_ok[k];
                end
            end
            if (!stg_hit) begin
                if (lo_done && (lo_done_dest == src_addr)) begin
                    sel = SEL_W'(SEL_LO(NUM_STG));
                end else if (src_busy) begin
                    lo_stall = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bypass_scoreboard.sv
// bypass_scoreboard: operand bypass selection and interlock for the in-order
// pipeline, plus a register scoreboard for long-latency producers that
// complete outside the pipeline. Optional perf counters under BYPASS_PERF_EN.
module bypass_scoreboard
    import bypass_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int NUM_STG = 3,
    parameter int SEL_W   = $clog2(NUM_STG + 2)
) (
    input  logic              clk,
    input  logic              resetn,
    bypass_scoreboard_if.slave bif
);

    logic [31:0]        busy_q;
    logic [31:0]        busy_d;
    logic [NUM_SRC-1:0] ld_stall;
    logic [NUM_SRC-1:0] lo_stall;
    logic [SEL_W-1:0]   sel_arr [NUM_SRC];
    logic               stall;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        logic [REG_AW-1:0] addr;
        assign addr = bif.id_src_addr[g*REG_AW +: REG_AW];

        bypass_match #(
            .NUM_STG (NUM_STG),
            .SEL_W   (SEL_W)
        ) u_match (
            .src_en       (bif.id_src_en[g]),
            .src_addr     (addr),
            .src_busy     (busy_q[addr]),
            .stg_gr_we    (bif.stg_gr_we),
            .stg_dest     (bif.stg_dest),
            .stg_data_ok  (bif.stg_data_ok),
            .lo_done      (bif.lo_done),
            .lo_done_dest (bif.lo_done_dest),
            .sel          (sel_arr[g]),
            .ld_stall     (ld_stall[g]),
            .lo_stall     (lo_stall[g])
        );
    end

    // Pack per-operand selects and combine operand stalls
    always_comb begin
        bif.src_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            bif.src_sel[i*SEL_W +: SEL_W] = sel_arr[i];
        end
    end

    assign stall        = |ld_stall || |lo_stall;
    assign bif.stall    = stall;
    assign bif.busy_vec = busy_q;

    // Scoreboard next state: issue applied after clear so a new op wins;
    // an issue while ID is held never left ID and is dropped
    always_comb begin
        busy_d = busy_q;
        if (bif.lo_done) begin
            busy_d[bif.lo_done_dest] = 1'b0;
        end
        if (bif.lo_issue && !stall && (bif.lo_dest != '0)) begin
            busy_d[bif.lo_dest] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

`ifdef BYPASS_PERF_EN
    logic [31:0] perf_ld_q;
    logic [31:0] perf_ld_d;
    logic [31:0] perf_lo_q;
    logic [31:0] perf_lo_d;
    logic        ld_any;
    logic        lo_only;

    assign ld_any  = |ld_stall;
    assign lo_only = stall && !ld_any;

    // Saturating stall-cause counters
    always_comb begin
        perf_ld_d = perf_ld_q;
        perf_lo_d = perf_lo_q;
        if (ld_any && (perf_ld_q != 32'hFFFF_FFFF)) begin
            perf_ld_d = perf_ld_q + 32'd1;
        end
        if (lo_only && (perf_lo_q != 32'hFFFF_FFFF)) begin
            perf_lo_d = perf_lo_q + 32'd1;
        end
    end

    // Perf counter registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_ld_q <= '0;
            perf_lo_q <= '0;
        end else begin
            perf_ld_q <= perf_ld_d;
            perf_lo_q <= perf_lo_d;
        end
    end

    assign bif.perf_ld_stall = perf_ld_q;
    assign bif.perf_lo_stall = perf_lo_q;
`endif

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Directed bench for bypass_scoreboard: bypass priority, load-use interlock,
// long-op scoreboard, r0 handling and asynchronous reset.
module tb_bypass_scoreboard;

    localparam int NUM_SRC = 2;
    localparam int NUM_STG = 3;
    localparam int SEL_W   = $clog2(NUM_STG + 2);
    localparam int SEL_LO  = NUM_STG + 1;

    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_err;

    bypass_scoreboard_if #(.NUM_SRC(NUM_SRC), .NUM_STG(NUM_STG), .SEL_W(SEL_W)) bif ();

    bypass_scoreboard #(
        .NUM_SRC (NUM_SRC),
        .NUM_STG (NUM_STG),
        .SEL_W   (SEL_W)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bif    (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sel_of(input int i);
        return 32'(bif.src_sel[i*SEL_W +: SEL_W]);
    endfunction

    task automatic idle();
        bif.id_src_en    = '0;
        bif.id_src_addr  = '0;
        bif.stg_gr_we    = '0;
        bif.stg_dest     = '0;
        bif.stg_data_ok  = '0;
        bif.lo_issue     = 1'b0;
        bif.lo_dest      = '0;
        bif.lo_done      = 1'b0;
        bif.lo_done_dest = '0;
    endtask

    task automatic src(input int i, input logic en, input logic [4:0] addr);
        bif.id_src_en[i]          = en;
        bif.id_src_addr[i*5 +: 5] = addr;
    endtask

    task automatic stg(input int k, input logic we, input logic [4:0] dest, input logic ok);
        bif.stg_gr_we[k]       = we;
        bif.stg_dest[k*5 +: 5] = dest;
        bif.stg_data_ok[k]     = ok;
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling
    task automatic settle();
        #2;
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        resetn = 1'b0;
        idle();
        #12;
        chk("reset_busy", bif.busy_vec, 32'h0);
        chk("reset_stall", 32'(bif.stall), 32'h0);
        chk("reset_sel", 32'(bif.src_sel), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // Youngest stage wins over an older stage writing the same register
        stg(0, 1'b1, 5'd5, 1'b1);
        stg(2, 1'b1, 5'd5, 1'b1);
        src(0, 1'b1, 5'd5);
        settle();
        chk("young_sel", sel_of(0), 32'd1);
        chk("young_stall", 32'(bif.stall), 32'h0);
        stg(0, 1'b0, 5'd0, 1'b0);
        settle();
        chk("old_sel", sel_of(0), 32'd3);
        tick();

        // Load-use: stage 0 has no data yet
        idle();
        stg(0, 1'b1, 5'd7, 1'b0);
        src(1, 1'b1, 5'd7);
        settle();
        chk("ld_stall", 32'(bif.stall), 32'h1);
        chk("ld_sel", sel_of(1), 32'd1);
        tick();
        stg(0, 1'b1, 5'd7, 1'b1);
        settle();
        chk("ld_ok_stall", 32'(bif.stall), 32'h0);
        tick();

        // Disabled operand ignores a pending load
        idle();
        stg(0, 1'b1, 5'd7, 1'b0);
        src(1, 1'b0, 5'd7);
        settle();
        chk("dis_stall", 32'(bif.stall), 32'h0);
        chk("dis_sel", sel_of(1), 32'd0);
        tick();

        // Long op to r9 issued at t, readers blocked t+1..t+4
        idle();
        bif.lo_issue = 1'b1;
        bif.lo_dest  = 5'd9;
        tick();
        idle();
        src(0, 1'b1, 5'd9);
        for (int c = 1; c <= 4; c++) begin
            // at t+1 also try a second issue while stalled; it must be dropped
            bif.lo_issue = (c == 1);
            bif.lo_dest  = (c == 1) ? 5'd11 : 5'd0;
            settle();
            chk($sformatf("lo_stall_t%0d", c), 32'(bif.stall), 32'h1);
            chk($sformatf("lo_busy_t%0d", c), bif.busy_vec, 32'h200);
            tick();
        end
        bif.lo_issue     = 1'b0;
        bif.lo_dest      = 5'd0;
        bif.lo_done      = 1'b1;
        bif.lo_done_dest = 5'd9;
        settle();
        chk("lo_done_sel", sel_of(0), 32'(SEL_LO));
        chk("lo_done_stall", 32'(bif.stall), 32'h0);
        tick();
        bif.lo_done = 1'b0;
        settle();
        chk("lo_after_busy", bif.busy_vec, 32'h0);
        chk("lo_after_sel", sel_of(0), 32'd0);
        chk("lo_after_stall", 32'(bif.stall), 32'h0);

        // Stage match outranks the completion bus
        idle();
        stg(1, 1'b1, 5'd12, 1'b1);
        bif.lo_done      = 1'b1;
        bif.lo_done_dest = 5'd12;
        src(0, 1'b1, 5'd12);
        settle();
        chk("stg_over_lo", sel_of(0), 32'd2);
        tick();

        // Same-cycle issue and done on busy r3: stays busy
        idle();
        bif.lo_issue = 1'b1;
        bif.lo_dest  = 5'd3;
        tick();
        settle();
        chk("r3_busy", bif.busy_vec, 32'h8);
        bif.lo_done      = 1'b1;
        bif.lo_done_dest = 5'd3;
        tick();
        idle();
        settle();
        chk("r3_set_wins", bif.busy_vec, 32'h8);
        bif.lo_done      = 1'b1;
        bif.lo_done_dest = 5'd3;
        tick();
        // done for a register that is not busy is a no-op
        bif.lo_done_dest = 5'd20;
        tick();
        idle();
        settle();
        chk("r3_cleared", bif.busy_vec, 32'h0);

        // r0 source against every stage writing r0, none with data
        for (int k = 0; k < NUM_STG; k++) stg(k, 1'b1, 5'd0, 1'b0);
        src(0, 1'b1, 5'd0);
        src(1, 1'b1, 5'd0);
        bif.lo_issue = 1'b1;
        bif.lo_dest  = 5'd0;
        settle();
        chk("r0_sel", 32'(bif.src_sel), 32'h0);
        chk("r0_stall", 32'(bif.stall), 32'h0);
        tick();
        idle();
        settle();
        chk("r0_busy", bif.busy_vec, 32'h0);

        // Async reset during a scoreboard stall
        bif.lo_issue = 1'b1;
        bif.lo_dest  = 5'd9;
        tick();
        idle();
        src(0, 1'b1, 5'd9);
        settle();
        chk("pre_rst_stall", 32'(bif.stall), 32'h1);
        resetn = 1'b0;
        #1;
        chk("rst_busy", bif.busy_vec, 32'h0);
        chk("rst_stall", 32'(bif.stall), 32'h0);
`ifdef BYPASS_PERF_EN
        chk("rst_perf_ld", bif.perf_ld_stall, 32'h0);
        chk("rst_perf_lo", bif.perf_lo_stall, 32'h0);
`endif
        #20;
        chk("rst_hold_busy", bif.busy_vec, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
